fetch_queue_ctrl: RTL

Parametrised fetch-buffer controller. Replaces the fixed two-half fetch FSM with an N-slot circular line queue.
- Requests line-aligned I-cache lines and stores hits.
- Presents the decoder a two-line window: head and head+1.
- Retires the head line on decoder advance; flushes on redirect.
- Sits between the I-cache and the decode stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_line_buf.sv | 23 ++
 rtl/fetch_queue_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default geometry for the fetch queue.
package fetch_pkg;
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_RUN  = 2'b01,
    FETCH_FULL = 2'b11
  } fetch_st_e;
  localparam int DEF_SLOTS  = 4;
  localparam int DEF_LINE   = 16;
  localparam int DEF_ADDR_W = 32;
  localparam int PTR_W = $clog2(DEF_SLOTS);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(DEF_LINE);
endpackage

// File: rtl/fetch_line_buf.sv
// fetch_line_buf: circular line storage, one write port, head/head+1 read ports.
module fetch_line_buf #(
  parameter int NUM_SLOTS  = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_SLOTS)-1:0] wr_ptr,
  input  logic [LINE_BYTES*8-1:0]      wr_data,
  input  logic [$clog2(NUM_SLOTS)-1:0] rd_ptr,
  output logic [LINE_BYTES*8-1:0]      rd0,
  output logic [LINE_BYTES*8-1:0]      rd1
);
  localparam int PW = $clog2(NUM_SLOTS);
  logic [LINE_BYTES*8-1:0] mem [NUM_SLOTS];
  logic [PW-1:0] rd_nxt;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= wr_data;
  // power-of-two depth: pointer overflow is the wrap
  assign rd_nxt = rd_ptr + 1'b1;
  assign rd0 = mem[rd_ptr];
  assign rd1 = mem[rd_nxt];
endmodule

// File: rtl/fetch_queue_ctrl.sv
// fetch_queue_ctrl: N-slot fetch line queue presenting a two-line decode window.
// Define FETCH_BYPASS_EN to forward a hit straight to the window when the queue is empty.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_SLOTS,
  parameter int LINE_BYTES = DEF_LINE,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          f_redirect,
  input  logic [ADDR_W-1:0]             f_redirect_addr,
  input  logic                          ic_hit,
  input  logic [LINE_BYTES*8-1:0]       ic_data,
  input  logic                          de_adv,
  output logic                          f_ic_req,
  output logic [ADDR_W-1:0]             f_ic_addr,
  output logic [2*LINE_BYTES*8-1:0]     f_win,
  output logic [1:0]                    f_win_vld,
  output logic [ADDR_W-1:0]             f_win_base,
  output logic [$clog2(LINE_BYTES)-1:0] f_start_off,
  output logic [$clog2(NUM_SLOTS):0]    f_count,
  output logic [1:0]                    f_curr_st
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int OW = $clog2(LINE_BYTES);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(LINE_BYTES);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(NUM_SLOTS);
  fetch_st_e st, st_nxt;
  logic [PW-1:0] head, tail;
  logic [PW:0] count, count_nxt;
  logic [ADDR_W-1:0] ic_addr, win_base;
  logic [OW-1:0] start_off;
  logic hit, adv, byp, consume, wr;
  logic [LINE_BYTES*8-1:0] rd0, rd1;
  fetch_line_buf #(.NUM_SLOTS(NUM_SLOTS), .LINE_BYTES(LINE_BYTES)) u_buf (
    .clk    (clk),
    .wr_en  (wr),
    .wr_ptr (tail),
    .wr_data(ic_data),
    .rd_ptr (head),
    .rd0    (rd0),
    .rd1    (rd1)
  );
  assign f_ic_req = st == FETCH_RUN;
  assign hit = f_ic_req & ic_hit;
  assign adv = de_adv & (count != '0);
`ifdef FETCH_BYPASS_EN
  assign byp = hit & (count == '0);
`else
  assign byp = 1'b0;
`endif
  // a bypassed line retired in the same cycle never enters the queue
  assign consume = byp & de_adv;
  assign wr = hit & ~consume;
  assign count_nxt = count + (PW+1)'(wr) - (PW+1)'(adv);
  always_comb
    st_nxt = f_redirect ? FETCH_RUN :
             (st == FETCH_RUN && count_nxt == FULL_CNT) ? FETCH_FULL :
             (st == FETCH_FULL && de_adv) ? FETCH_RUN : st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= FETCH_IDLE;
    else st <= st_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      ic_addr <= '0;
      win_base <= '0;
      start_off <= '0;
    end else if (f_redirect) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      ic_addr <= {f_redirect_addr[ADDR_W-1:OW], OW'(0)};
      win_base <= {f_redirect_addr[ADDR_W-1:OW], OW'(0)};
      start_off <= f_redirect_addr[OW-1:0];
    end else begin
      if (adv) head <= head + 1'b1;
      if (wr) tail <= tail + 1'b1;
      count <= count_nxt;
      if (hit) ic_addr <= ic_addr + STEP;
      if (adv | consume) begin
        win_base <= win_base + STEP;
        start_off <= '0;
      end
    end
  assign f_win_vld = byp ? 2'b01 : {count >= (PW+1)'(2), count != '0};
  assign f_win = {rd1, byp ? ic_data : rd0};
  assign f_win_base = byp ? ic_addr : win_base;
  assign f_ic_addr = ic_addr;
  assign f_start_off = start_off;
  assign f_count = count;
  assign f_curr_st = st;
endmodule
